// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RISC-V opcodes, NOP word and the control-stage entry type.
// Macro ALU_CTRL_ILLEGAL_EN adds the illegal flag to each buffered entry.
package alu_pkg;

    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_ADDI = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OP_SRLI = 4'b0011;
    localparam logic [3:0] ALU_OP_LUI  = 4'b1000;
    localparam logic [3:0] ALU_OP_ORI  = 4'b1001;
    localparam logic [3:0] ALU_OP_SLLI = 4'b1100;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  op;
`ifdef ALU_CTRL_ILLEGAL_EN
        logic        illegal;
`endif
    } entry_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational instruction-to-ALU-operation decoder.
// Macro ALU_CTRL_ILLEGAL_EN adds illegal_o for unsupported encodings.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  op_o
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    output logic        illegal_o
`endif
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    always_comb begin
        op_o = ALU_OP_ADD;
`ifdef ALU_CTRL_ILLEGAL_EN
        illegal_o = 1'b0;
`endif
        casez ({f7, f3, opc})
            {7'b???????, 3'b???, OPC_LUI}:    op_o = ALU_OP_LUI;
            {7'b???????, 3'b110, OPC_OP_IMM}: op_o = ALU_OP_ORI;
            {7'b???????, 3'b000, OPC_OP_IMM}: op_o = ALU_OP_ADDI;
            {F7_ZERO,    3'b001, OPC_OP_IMM}: op_o = ALU_OP_SLLI;
            {F7_ZERO,    3'b101, OPC_OP_IMM}: op_o = ALU_OP_SRLI;
            {F7_ZERO,    3'b000, OPC_OP}:     op_o = ALU_OP_ADD;
            {F7_ALT,     3'b000, OPC_OP}:     op_o = ALU_OP_SUB;
            {7'b???????, 3'b???, OPC_LOAD},
            {7'b???????, 3'b???, OPC_STORE},
            {7'b???????, 3'b???, OPC_JAL},
            {7'b???????, 3'b???, OPC_JALR}:   op_o = ALU_OP_ADD;
            // beq/bne compare by subtraction
            {7'b???????, 3'b00?, OPC_BRANCH}: op_o = ALU_OP_SUB;
            default: begin
                op_o = ALU_OP_ADD;
`ifdef ALU_CTRL_ILLEGAL_EN
                illegal_o = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/alu_control_stage.sv
// ALU control stage: decodes on input, buffers decoded entries in a 2-entry skid buffer.
// Macro ALU_CTRL_ILLEGAL_EN adds the Illegal_o port and stores the illegal flag per entry.
//   state    | meaning
//   ST_EMPTY | no entries, outputs idle (NOP)
//   ST_ONE   | head valid, skid free
//   ST_FULL  | head and skid valid, input stalled
module alu_control_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction_i,
    input  logic        In_Valid_i,
    output logic        In_Ready_o,
    input  logic        Flush_i,
    output logic        Out_Valid_o,
    input  logic        Out_Ready_i,
    output logic [3:0]  ALU_Operation_o,
    output logic [31:0] Instruction_o
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    output logic        Illegal_o
`endif
);

    buf_state_e state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    entry_t     dec_entry;
    entry_t     idle_entry;
    logic       in_ready_q, in_ready_d;
    logic       out_valid;
    logic       xfer_in, xfer_out;
    logic [3:0] dec_op;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic       dec_illegal;
`endif

    alu_op_decoder u_dec (
        .instr_i   (Instruction_i),
        .op_o      (dec_op)
`ifdef ALU_CTRL_ILLEGAL_EN
        ,
        .illegal_o (dec_illegal)
`endif
    );

    always_comb begin
        dec_entry.instr  = Instruction_i;
        dec_entry.op     = dec_op;
        idle_entry.instr = INSTR_NOP;
        idle_entry.op    = ALU_OP_ADD;
`ifdef ALU_CTRL_ILLEGAL_EN
        dec_entry.illegal  = dec_illegal;
        idle_entry.illegal = 1'b0;
`endif
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign xfer_in   = In_Valid_i & in_ready_q;
    assign xfer_out  = out_valid & Out_Ready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (xfer_in) state_d = ST_ONE;
            ST_ONE: begin
                if (xfer_in && !xfer_out)      state_d = ST_FULL;
                else if (!xfer_in && xfer_out) state_d = ST_EMPTY;
            end
            ST_FULL:  if (xfer_out) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        if (Flush_i) state_d = ST_EMPTY;
        // Registered ready looks at the next state so it never depends on Out_Ready_i combinationally
        in_ready_d = (state_d != ST_FULL);
    end

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        case (state_q)
            ST_EMPTY: if (xfer_in) head_d = dec_entry;
            ST_ONE: begin
                if (xfer_in && xfer_out) head_d = dec_entry;
                else if (xfer_in)        skid_d = dec_entry;
            end
            ST_FULL:  if (xfer_out) head_d = skid_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= idle_entry;
            skid_q <= idle_entry;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    always_comb begin
        In_Ready_o      = in_ready_q;
        Out_Valid_o     = out_valid;
        ALU_Operation_o = out_valid ? head_q.op    : ALU_OP_ADD;
        Instruction_o   = out_valid ? head_q.instr : INSTR_NOP;
`ifdef ALU_CTRL_ILLEGAL_EN
        Illegal_o       = out_valid ? head_q.illegal : 1'b0;
`endif
    end

endmodule

// File: tb/tb_alu_control_stage.sv
// Directed and scoreboarded checks for alu_control_stage; adapts to ALU_CTRL_ILLEGAL_EN.
module tb_alu_control_stage;

    logic        clk;
    logic        reset;
    logic [31:0] Instruction_i;
    logic        In_Valid_i;
    logic        In_Ready_o;
    logic        Flush_i;
    logic        Out_Valid_o;
    logic        Out_Ready_i;
    logic [3:0]  ALU_Operation_o;
    logic [31:0] Instruction_o;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic        Illegal_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_control_stage dut (
        .clk             (clk),
        .reset           (reset),
        .Instruction_i   (Instruction_i),
        .In_Valid_i      (In_Valid_i),
        .In_Ready_o      (In_Ready_o),
        .Flush_i         (Flush_i),
        .Out_Valid_o     (Out_Valid_o),
        .Out_Ready_i     (Out_Ready_i),
        .ALU_Operation_o (ALU_Operation_o),
        .Instruction_o   (Instruction_o)
`ifdef ALU_CTRL_ILLEGAL_EN
        ,
        .Illegal_o       (Illegal_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ov"},  {63'd0, Out_Valid_o}, 64'd0);
        check({tag, "_op"},  {60'd0, ALU_Operation_o}, 64'd0);
        check({tag, "_ins"}, {32'd0, Instruction_o}, 64'h13);
`ifdef ALU_CTRL_ILLEGAL_EN
        check({tag, "_ill"}, {63'd0, Illegal_o}, 64'd0);
`endif
    endtask

    task automatic check_head(input string tag, input logic [31:0] ins, input logic [3:0] op);
        check({tag, "_ov"},  {63'd0, Out_Valid_o}, 64'd1);
        check({tag, "_op"},  {60'd0, ALU_Operation_o}, {60'd0, op});
        check({tag, "_ins"}, {32'd0, Instruction_o}, {32'd0, ins});
    endtask

    // Legal instruction with the operation code it must produce
    task automatic gen_legal(output logic [31:0] ins, output logic [3:0] op);
        int k;
        k   = $urandom_range(0, 12);
        ins = $urandom;
        case (k)
            0:  begin ins[6:0] = 7'b0010011; ins[14:12] = 3'b000; op = 4'b0000; end
            1:  begin ins[6:0] = 7'b0010011; ins[14:12] = 3'b110; op = 4'b1001; end
            2:  begin ins[6:0] = 7'b0010011; ins[14:12] = 3'b001; ins[31:25] = 7'b0000000; op = 4'b1100; end
            3:  begin ins[6:0] = 7'b0010011; ins[14:12] = 3'b101; ins[31:25] = 7'b0000000; op = 4'b0011; end
            4:  begin ins[6:0] = 7'b0110011; ins[14:12] = 3'b000; ins[31:25] = 7'b0000000; op = 4'b0000; end
            5:  begin ins[6:0] = 7'b0110011; ins[14:12] = 3'b000; ins[31:25] = 7'b0100000; op = 4'b0001; end
            6:  begin ins[6:0] = 7'b0110111; op = 4'b1000; end
            7:  begin ins[6:0] = 7'b0000011; op = 4'b0000; end
            8:  begin ins[6:0] = 7'b0100011; op = 4'b0000; end
            9:  begin ins[6:0] = 7'b1101111; op = 4'b0000; end
            10: begin ins[6:0] = 7'b1100111; op = 4'b0000; end
            11: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b000; op = 4'b0001; end
            default: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b001; op = 4'b0001; end
        endcase
    endtask

    logic [35:0] sb_q[$];
    logic [31:0] r_ins;
    logic [3:0]  r_op;
    int          sent, got, cyc;
    logic        pushed;

    initial begin
        reset         = 1'b1;
        Instruction_i = 32'h0;
        In_Valid_i    = 1'b0;
        Flush_i       = 1'b0;
        Out_Ready_i   = 1'b0;

        #3;
        check_idle("rst");
        check("rst_rdy", {63'd0, In_Ready_o}, 64'd0);
        tick();
        reset = 1'b0;
        check("rst_rdy_low", {63'd0, In_Ready_o}, 64'd0);
        tick();
        check("rdy_rise", {63'd0, In_Ready_o}, 64'd1);
        check_idle("post_rst");

        // single addi, one-cycle latency
        In_Valid_i = 1'b1; Instruction_i = 32'h0010_0093; Out_Ready_i = 1'b1;
        tick();
        In_Valid_i = 1'b0;
        check_head("addi", 32'h0010_0093, 4'b0000);
`ifdef ALU_CTRL_ILLEGAL_EN
        check("addi_ill", {63'd0, Illegal_o}, 64'd0);
`endif
        tick();
        check_idle("addi_drain");
        check("addi_rdy", {63'd0, In_Ready_o}, 64'd1);

        // stream of three against a stalled ALU
        Out_Ready_i = 1'b0;
        In_Valid_i = 1'b1; Instruction_i = 32'h40C3_0333;
        tick();
        check_head("s1", 32'h40C3_0333, 4'b0001);
        check("s1_rdy", {63'd0, In_Ready_o}, 64'd1);
        Instruction_i = 32'h0020_9093;
        tick();
        check("s2_rdy", {63'd0, In_Ready_o}, 64'd0);
        check_head("s2", 32'h40C3_0333, 4'b0001);
        Instruction_i = 32'h1234_50B7;
        tick();
        check("s3_rdy", {63'd0, In_Ready_o}, 64'd0);
        check_head("s3_hold", 32'h40C3_0333, 4'b0001);
        Out_Ready_i = 1'b1;
        tick();
        check_head("s4", 32'h0020_9093, 4'b1100);
        check("s4_rdy", {63'd0, In_Ready_o}, 64'd1);
        tick();
        In_Valid_i = 1'b0;
        check_head("s5", 32'h1234_50B7, 4'b1000);
        tick();
        check_idle("s6");

        // unsupported sll
        Out_Ready_i = 1'b0;
        In_Valid_i = 1'b1; Instruction_i = 32'h0000_1033;
        tick();
        In_Valid_i = 1'b0;
        check_head("sll", 32'h0000_1033, 4'b0000);
`ifdef ALU_CTRL_ILLEGAL_EN
        check("sll_ill", {63'd0, Illegal_o}, 64'd1);
`endif
        Out_Ready_i = 1'b1;
        tick();
        check_idle("sll_drain");

        // flush while FULL with a simultaneous new instruction
        Out_Ready_i = 1'b0;
        In_Valid_i = 1'b1; Instruction_i = 32'h0010_0093;
        tick();
        Instruction_i = 32'h40C3_0333;
        tick();
        check("fl_full_rdy", {63'd0, In_Ready_o}, 64'd0);
        Flush_i = 1'b1; Instruction_i = 32'h1234_50B7;
        tick();
        Flush_i = 1'b0; In_Valid_i = 1'b0;
        check_idle("fl_full");
        check("fl_full_rdy2", {63'd0, In_Ready_o}, 64'd1);
        tick();
        check_idle("fl_full_after");

        // flush in ONE overrides an accepted transfer-in
        In_Valid_i = 1'b1; Instruction_i = 32'h0020_9093;
        tick();
        check_head("fl_one_pre", 32'h0020_9093, 4'b1100);
        Flush_i = 1'b1; Instruction_i = 32'h1234_50B7;
        tick();
        Flush_i = 1'b0; In_Valid_i = 1'b0;
        check_idle("fl_one");
        tick();
        check_idle("fl_one_after");

        // random legal stream, Out_Ready_i toggling, scoreboard order check
        sent = 0; got = 0; cyc = 0;
        gen_legal(r_ins, r_op);
        In_Valid_i = 1'b1; Instruction_i = r_ins;
        while (got < 1000 && cyc < 5000) begin
            Out_Ready_i = (cyc % 2) == 1;
            @(negedge clk);
            pushed = 1'b0;
            if (Out_Valid_o && Out_Ready_i) begin
                if (sb_q.size() == 0) begin
                    check("rnd_extra", {28'd0, Instruction_o, ALU_Operation_o}, 64'd0);
                end else begin
                    check("rnd_entry", {28'd0, Instruction_o, ALU_Operation_o}, {28'd0, sb_q[0]});
                    void'(sb_q.pop_front());
                end
                got++;
            end
            if (In_Valid_i && In_Ready_o) begin
                sb_q.push_back({r_ins, r_op});
                sent++;
                pushed = 1'b1;
            end
            tick();
            if (pushed) begin
                if (sent < 1000) begin
                    gen_legal(r_ins, r_op);
                    Instruction_i = r_ins;
                end else begin
                    In_Valid_i = 1'b0;
                end
            end
            cyc++;
        end
        In_Valid_i = 1'b0;
        check("rnd_got", 64'(got), 64'd1000);
        check("rnd_left", 64'(sb_q.size()), 64'd0);

        // asynchronous reset while FULL
        Out_Ready_i = 1'b0;
        In_Valid_i = 1'b1; Instruction_i = 32'h40C3_0333;
        tick();
        Instruction_i = 32'h0020_9093;
        tick();
        In_Valid_i = 1'b0;
        check("ar_full_rdy", {63'd0, In_Ready_o}, 64'd0);
        check_head("ar_full", 32'h40C3_0333, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        check_idle("ar");
        check("ar_rdy", {63'd0, In_Ready_o}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check("ar_rdy_rise", {63'd0, In_Ready_o}, 64'd1);
        check_idle("ar_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
